// File: rtl/tdm_demux_if.sv
// Bundle of the serial-link inputs and parallel frame outputs of tdm_demux.
// The master side drives the serial stream; the slave side is the demux.
interface tdm_demux_if #(
    parameter int CH = 2,
    parameter int W  = 8
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic            DEMUX_en;
    logic            DEMUX_sync;
    logic            DEMUX_in;
    logic [CH*W-1:0] DEMUX_out;
    logic            DEMUX_valid;
    logic [SW-1:0]   DEMUX_sel;
    logic            DEMUX_locked;
    logic            DEMUX_err;

    modport master (
        output DEMUX_en, DEMUX_sync, DEMUX_in,
        input  DEMUX_out, DEMUX_valid, DEMUX_sel, DEMUX_locked, DEMUX_err
    );

    modport slave (
        input  DEMUX_en, DEMUX_sync, DEMUX_in,
        output DEMUX_out, DEMUX_valid, DEMUX_sel, DEMUX_locked, DEMUX_err
    );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: rebuilds one W-bit word per channel from a
// bit-interleaved serial stream (channel-major per bit, MSB first) aligned
// by a sync strobe, and publishes each complete frame with a valid pulse.
module tdm_demux #(
    parameter int CH = 2,
    parameter int W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    tdm_demux_if.slave bus
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int FW = CH * W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [BW-1:0]   b_reg, b_next;
    logic [FW-1:0]   shadow_reg, shadow_next;
    logic [FW-1:0]   out_reg, out_next;
    logic            valid_reg, valid_next;
    logic            err_reg, err_next;

    // One-hot map of the shadow bit addressed by the current (s, b) pair,
    // and the fixed position of channel 0 MSB used when a frame restarts.
    logic [FW-1:0]   hit;
    logic [FW-1:0]   start_bit;
    logic [FW-1:0]   captured;
    logic [FW-1:0]   restarted;

    genvar gi;
    generate
        for (gi = 0; gi < FW; gi++) begin : g_map
            assign hit[gi]       = (s_reg == SW'(gi / W)) && (b_reg == BW'(gi % W));
            assign start_bit[gi] = (gi == W - 1);
        end
    endgenerate

    assign captured  = (shadow_reg & ~hit)       | (hit       & {FW{bus.DEMUX_in}});
    assign restarted = (shadow_reg & ~start_bit) | (start_bit & {FW{bus.DEMUX_in}});

    wire at_boundary = (s_reg == '0) && (b_reg == BW'(W - 1));
    wire last_slot   = (s_reg == SW'(CH - 1));
    wire last_bit    = (b_reg == '0);

    // State, counters, shadow and published frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            s_reg      <= '0;
            b_reg      <= BW'(W - 1);
            shadow_reg <= '0;
            out_reg    <= '0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            s_reg      <= s_next;
            b_reg      <= b_next;
            shadow_reg <= shadow_next;
            out_reg    <= out_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
        end
    end

    // Next-state: capture routing, frame completion and resync handling.
    always_comb begin
        state_next  = state_reg;
        s_next      = s_reg;
        b_next      = b_reg;
        shadow_next = shadow_reg;
        out_next    = out_reg;
        valid_next  = 1'b0;
        err_next    = 1'b0;

        if (bus.DEMUX_en) begin
            unique case (state_reg)
                IDLE: begin
                    if (bus.DEMUX_sync) begin
                        shadow_next = restarted;
                        s_next      = SW'(1);
                        b_next      = BW'(W - 1);
                        state_next  = RUN;
                    end
                end
                RUN: begin
                    if (bus.DEMUX_sync && !at_boundary) begin
                        // Misaligned sync wins: drop the partial frame.
                        err_next    = 1'b1;
                        shadow_next = restarted;
                        s_next      = SW'(1);
                        b_next      = BW'(W - 1);
                    end else begin
                        shadow_next = captured;
                        if (last_slot) begin
                            s_next = '0;
                            if (last_bit) begin
                                b_next     = BW'(W - 1);
                                out_next   = captured;
                                valid_next = 1'b1;
                            end else begin
                                b_next = b_reg - BW'(1);
                            end
                        end else begin
                            s_next = s_reg + SW'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.DEMUX_out    = out_reg;
    assign bus.DEMUX_valid  = valid_reg;
    assign bus.DEMUX_sel    = s_reg;
    assign bus.DEMUX_locked = (state_reg == RUN);
    assign bus.DEMUX_err    = err_reg;
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed scenarios followed by a random stream, all
// checked every cycle against a frame-position reference model.
module tb_tdm_demux;
    localparam int CH = 2;
    localparam int W  = 8;
    localparam int FW = CH * W;
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdm_demux_if #(.CH(CH), .W(W)) bus ();

    tdm_demux #(.CH(CH), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: position within the frame counted linearly 0..FW-1.
    // Position p carries channel p%CH, bit W-1-p/CH.
    bit            m_locked;
    int            m_pos;
    logic [FW-1:0] m_frame;
    logic [FW-1:0] exp_out;
    logic          exp_valid;
    logic          exp_err;

    task automatic model_reset();
        m_locked  = 1'b0;
        m_pos     = 0;
        m_frame   = '0;
        exp_out   = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [SW-1:0] exp_sel;
        exp_sel = m_locked ? SW'(m_pos % CH) : '0;
        compared += 5;
        assert (bus.DEMUX_out === exp_out) else begin
            mismatched++;
            $error("FAIL %s out: observed %h expected %h", tag, bus.DEMUX_out, exp_out);
        end
        assert (bus.DEMUX_valid === exp_valid) else begin
            mismatched++;
            $error("FAIL %s valid: observed %b expected %b", tag, bus.DEMUX_valid, exp_valid);
        end
        assert (bus.DEMUX_err === exp_err) else begin
            mismatched++;
            $error("FAIL %s err: observed %b expected %b", tag, bus.DEMUX_err, exp_err);
        end
        assert (bus.DEMUX_sel === exp_sel) else begin
            mismatched++;
            $error("FAIL %s sel: observed %0d expected %0d", tag, bus.DEMUX_sel, exp_sel);
        end
        assert (bus.DEMUX_locked === m_locked) else begin
            mismatched++;
            $error("FAIL %s locked: observed %b expected %b", tag, bus.DEMUX_locked, m_locked);
        end
    endtask

    // One clock: drive inputs, advance the model, check just after the edge.
    task automatic step(input bit en, input bit sync, input bit din, input string tag);
        bus.DEMUX_en   = en;
        bus.DEMUX_sync = sync;
        bus.DEMUX_in   = din;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (en) begin
            if (!m_locked) begin
                if (sync) begin
                    m_locked       = 1'b1;
                    m_frame[W-1]   = din;
                    m_pos          = 1;
                end
            end else if (sync && m_pos != 0) begin
                exp_err      = 1'b1;
                m_frame[W-1] = din;
                m_pos        = 1;
            end else begin
                m_frame[W * (m_pos % CH) + (W - 1 - m_pos / CH)] = din;
                m_pos++;
                if (m_pos == FW) begin
                    m_pos     = 0;
                    exp_out   = m_frame;
                    exp_valid = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        $display("step %-8s en=%0b sync=%0b in=%0b -> out=%h valid=%0b err=%0b sel=%0d locked=%0b",
                 tag, en, sync, din, bus.DEMUX_out, bus.DEMUX_valid, bus.DEMUX_err,
                 bus.DEMUX_sel, bus.DEMUX_locked);
    endtask

    function automatic bit frame_bit(input logic [FW-1:0] f, input int p);
        return f[W * (p % CH) + (W - 1 - p / CH)];
    endfunction

    // Serial frame with optional sync on bit 0, a stall of stall_n cycles
    // after bit stall_at, and last_stall cycles before the final bit.
    task automatic send_frame(input logic [FW-1:0] f, input bit sync_first,
                              input int stall_at, input int stall_n,
                              input int last_stall, input string tag);
        for (int p = 0; p < FW; p++) begin
            if (p == FW - 1)
                for (int k = 0; k < last_stall; k++) step(1'b0, 1'b0, 1'b1, tag);
            step(1'b1, sync_first && (p == 0), frame_bit(f, p), tag);
            if (p == stall_at)
                for (int k = 0; k < stall_n; k++) step(1'b0, 1'b1, 1'b0, tag);
        end
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        $display("reset %-8s asserted mid-cycle", tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.DEMUX_en   = 1'b0;
        bus.DEMUX_sync = 1'b0;
        bus.DEMUX_in   = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, "idle");

        // 1/2: basic frame, then free-running second frame without sync.
        send_frame({8'h3C, 8'hA5}, 1'b1, -1, 0, 0, "basic");
        send_frame({8'h00, 8'hFF}, 1'b0, -1, 0, 0, "freerun");

        // 3: stalls inside the frame and right before its last bit.
        send_frame({8'h3C, 8'hA5}, 1'b0, 5, 3, 1, "stall");

        // 4: misaligned sync on bit 7, then full frame from that point.
        for (int p = 0; p < 7; p++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), "partial");
        send_frame({8'h34, 8'h12}, 1'b1, -1, 0, 0, "resync");
        step(1'b1, 1'b1, 1'b1, "bndsync");
        for (int p = 1; p < FW; p++) step(1'b1, 1'b0, frame_bit({8'h34, 8'h12}, p), "bndsync");

        // 5: pre-lock behaviour after a reset.
        async_reset("rst1");
        for (int p = 0; p < 20; p++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), "nosync");
        step(1'b0, 1'b1, 1'b1, "ensync");
        step(1'b1, 1'b0, 1'b0, "nosync");

        // 6: reset after 10 bits, then a fresh frame.
        send_frame({8'h5A, 8'hC3}, 1'b1, -1, 0, 0, "pre6");
        for (int p = 0; p < 10; p++) step(1'b1, p == 0, 1'($urandom_range(0, 1)), "midfrm");
        async_reset("rst2");
        send_frame({8'h5A, 8'hC3}, 1'b1, -1, 0, 0, "fresh");

        // Random stream with occasional stalls and syncs.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)), "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive-side counterpart of the MUX2to1 selector. It takes a bit-interleaved serial stream, the kind a selector produces when its select line steps through channels every clock, and rebuilds one W-bit word per channel. Frame alignment comes from a sync strobe. The block delivers each completed frame in parallel with a one-cycle valid pulse and sits between a serial link input and per-channel consumer logic.

## Interface
Parameters:
- CH, default 2: number of interleaved channels (≥2).
- W, default 8: bits per channel per frame (≥2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- DEMUX_en  input  1  stream enable. When low, the cycle carries no bit and all state holds.
- DEMUX_sync  input  1  frame-start strobe. Qualified by DEMUX_en. Marks the cycle carrying channel 0, bit W-1.
- DEMUX_in  input  1  serial data bit.
- DEMUX_out  output  CH*W  last complete frame. Channel c is at DEMUX_out[W*c +: W].
- DEMUX_valid  output  1  one-cycle pulse when DEMUX_out updates.
- DEMUX_sel  output  max(1,$clog2(CH))  slot index of the next expected bit.
- DEMUX_locked  output  1  high while in RUN.
- DEMUX_err  output  1  one-cycle pulse on a misaligned sync.

## Operation
- A cycle is an active cycle when DEMUX_en=1. Inactive cycles change nothing, and DEMUX_valid/DEMUX_err return to 0.
- Counters:
  - slot counter s, range 0..CH-1.
  - bit counter b, range W-1..0, MSB first.
  - shadow register holds CH*W bits.
- Bit routing: each active bit in RUN is written to shadow[W*s + b]. s then increments. When s wraps CH-1→0, b decrements. When b wraps 0→W-1, the frame is complete.
- States:
  - IDLE:
    - DEMUX_locked=0. DEMUX_in is ignored unless sync is present.
    - An active cycle with DEMUX_sync=1 stores the bit as channel 0, bit W-1, sets s=1 and b=W-1, and enters RUN.
  - RUN:
    - DEMUX_locked=1. Every active cycle captures one bit.
    - Frame completion: on the edge sampling the last bit (s=CH-1, b=0), DEMUX_out loads the full frame including that bit. DEMUX_valid=1 for the following cycle. Counters return to s=0, b=W-1. The block stays in RUN and free-runs; sync at boundaries is optional.
    - Sync exactly at a boundary (s=0, b=W-1) is legal, with no error and no effect beyond normal capture.
    - Sync at any other position:
      - DEMUX_err pulses for one cycle.
      - The partial frame is discarded and DEMUX_out is unchanged.
      - The current bit becomes channel 0, bit W-1, with s=1 and b=W-1.
- DEMUX_sel shows s in both states. It is 0 in IDLE.
- Frame completion and misaligned sync cannot coincide, because completion occurs at s=CH-1 and b=0, which is not a legal sync position. The misaligned-sync rule takes precedence.
- Shadow bits not yet overwritten in the current frame are don't-care. Only full frames are ever published.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE. s=0, b=W-1. Shadow cleared.
  - DEMUX_out=0, DEMUX_valid=0, DEMUX_sel=0, DEMUX_locked=0, DEMUX_err=0.
- Reset asserted mid-frame drops the partial frame. The block resumes only on the next sync after rst deasserts.
- Latency: DEMUX_out and DEMUX_valid update 1 clock after the final bit of a frame is presented.
- With no stalls, a frame takes CH*W active cycles. DEMUX_valid pulses every CH*W cycles.
- DEMUX_locked rises on the edge that samples the first sync.
- DEMUX_err rises 1 clock after the misaligned sync bit is presented.
- Stalls (DEMUX_en=0) stretch a frame by exactly the number of stalled cycles. A stall on the completion edge delays completion until the next active cycle carrying the last bit.
- DEMUX_out is stable between valid pulses.

## Test plan
1. Basic frame. CH=2, W=8, no stalls. Sync on the first bit, then interleaved MSB-first bits of ch0=0xA5 and ch1=0x3C (16 active cycles).
   - Expect DEMUX_out=0x3CA5 and a DEMUX_valid pulse 1 clock after the 16th bit.
   - Expect DEMUX_locked=1 from the first edge.
   - Expect DEMUX_sel to toggle 1,0,1,…
2. Free-run. Two back-to-back frames: 0xA5/0x3C, then 0xFF/0x00, with sync only on the first.
   - Expect valid pulses 16 cycles apart, with DEMUX_out=0x3CA5 then 0x00FF.
   - Expect no DEMUX_err.
3. Stalls. Same data as scenario 1 with DEMUX_en=0 inserted for 3 cycles after bit 5 and 1 cycle on the final bit.
   - Expect DEMUX_out=0x3CA5 with valid 4 cycles later than in scenario 1.
   - Expect the stalled cycles to leave DEMUX_sel unchanged.
4. Misaligned sync. Sync again on bit 7 of a frame, then a full 0x12/0x34 frame from that point.
   - Expect a one-cycle DEMUX_err and no valid for the broken frame.
   - Then expect DEMUX_out=0x3412.
5. Pre-lock behaviour.
   - Bits with no sync: DEMUX_locked stays 0 and no valid occurs.
   - Sync with DEMUX_en=0: ignored.
6. Reset mid-frame.
   - Assert rst asynchronously after 10 bits: all outputs go to 0 immediately and the state is IDLE.
   - After deassertion, a fresh synced 0xC3/0x5A frame gives DEMUX_out=0x5AC3.
